// File: rtl/rem_seq_ctrl_if.sv
// Handshake bundle for the sequential signed-remainder unit.
// The master drives the request and operands. The slave returns the registered result and status.
interface rem_seq_ctrl_if #(
    parameter int WIDTH = 3
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             dz;

    modport master (output start, A, B, input  R, busy, done, dz);
    modport slave  (input  start, A, B, output R, busy, done, dz);
endinterface

// File: rtl/rem_seq_ctrl.sv
// Multi-cycle signed remainder R = A % B, truncated toward zero.
// Restoring division runs on the operand magnitudes and retires one dividend bit per cycle.
module rem_seq_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    rem_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t           r_state,  w_state_nxt;
    logic [WIDTH-1:0] r_dvd,    w_dvd_nxt;
    logic [WIDTH-1:0] r_mag_b,  w_mag_b_nxt;
    logic [WIDTH:0]   r_rem,    w_rem_nxt;
    logic [CW-1:0]    r_cnt,    w_cnt_nxt;
    logic [WIDTH-1:0] r_a_raw,  w_a_raw_nxt;
    logic             r_sign_a, w_sign_a_nxt;
    logic             r_zero,   w_zero_nxt;
    logic [WIDTH-1:0] r_r,      w_r_nxt;
    logic             r_busy,   w_busy_nxt;
    logic             r_done,   w_done_nxt;
    logic             r_dz,     w_dz_nxt;

    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_mag;
    logic [WIDTH:0]   w_trial, w_div;

    // The most-negative operand negates to itself. Read as unsigned, that value is the correct magnitude.
    assign w_abs_a = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign w_abs_b = bus.B[WIDTH-1] ? -bus.B : bus.B;
    assign w_trial = (r_rem << 1) | (WIDTH+1)'(r_dvd[WIDTH-1]);
    assign w_div   = {1'b0, r_mag_b};
    assign w_mag   = r_rem[WIDTH-1:0];

    // NOTE: every next-value signal gets a default before the case statement, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_dvd_nxt    = r_dvd;
        w_mag_b_nxt  = r_mag_b;
        w_rem_nxt    = r_rem;
        w_cnt_nxt    = r_cnt;
        w_a_raw_nxt  = r_a_raw;
        w_sign_a_nxt = r_sign_a;
        w_zero_nxt   = r_zero;
        w_r_nxt      = r_r;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_dz_nxt     = r_dz;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_dvd_nxt    = w_abs_a;
                    w_mag_b_nxt  = w_abs_b;
                    w_rem_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_a_raw_nxt  = bus.A;
                    w_sign_a_nxt = bus.A[WIDTH-1];
                    w_zero_nxt   = (bus.B == '0);
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = S_CALC;
                end
            end
            S_CALC: begin
                w_rem_nxt = (w_trial >= w_div) ? (w_trial - w_div) : w_trial;
                w_dvd_nxt = {r_dvd[WIDTH-2:0], 1'b0};
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == CW'(WIDTH - 1))
                    w_state_nxt = S_FIX;
            end
            S_FIX: begin
                if (r_zero) begin
                    w_r_nxt  = r_a_raw;
                    w_dz_nxt = 1'b1;
                end else begin
                    w_r_nxt  = r_sign_a ? -w_mag : w_mag;
                    w_dz_nxt = 1'b0;
                end
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_dvd    <= '0;
            r_mag_b  <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_a_raw  <= '0;
            r_sign_a <= 1'b0;
            r_zero   <= 1'b0;
            r_r      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dvd    <= w_dvd_nxt;
            r_mag_b  <= w_mag_b_nxt;
            r_rem    <= w_rem_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a_raw  <= w_a_raw_nxt;
            r_sign_a <= w_sign_a_nxt;
            r_zero   <= w_zero_nxt;
            r_r      <= w_r_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_dz     <= w_dz_nxt;
        end
    end

    assign bus.R    = r_r;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dz   = r_dz;
endmodule
